// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the mode-0 SPI master
package spi_pkg;

    localparam int SPI_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        TRAIL = 3'd4,
        GAP   = 3'd5
    } spi_state_t;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int div_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_en.sv
// rtl/spi_clk_en.sv - phase divider producing a one-cycle tick every DIV clocks
module spi_clk_en
    import spi_pkg::*;
#(
    parameter int DIV = 500,
    parameter int CW  = div_cnt_width(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          tick
);

    assign tick = (count == CW'(DIV - 1));

    // Free-running 0..DIV-1 counter; clear pins it at zero while the master idles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master, one full-duplex frame per start pulse
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 500,
    parameter int WIDTH   = SPI_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic             sck,
    output logic             ss,
    output logic             mosi,
    input  logic             miso
);

    localparam int CW = div_cnt_width(CLK_DIV);
    localparam int BW = div_cnt_width(WIDTH);

    spi_state_t       state;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic [BW-1:0]    bit_cnt;
    logic             miso_s1;
    logic             miso_s2;
    logic [CW-1:0]    div_count;
    logic             tick;
    logic             frame_active;
    logic             gap_entry;

    spi_clk_en #(
        .DIV (CLK_DIV),
        .CW  (CW)
    ) u_clk_en (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .count (div_count),
        .tick  (tick)
    );

    assign frame_active = (state == LEAD) || (state == HIGH) ||
                          (state == LOW)  || (state == TRAIL);
    // First cycle of GAP: the frame has just closed.
    assign gap_entry    = (state == GAP) && (div_count == '0);

    // Two-flop synchronizer; its latency is why a phase must be at least 4 clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
        end
    end

    // Phase sequencer; shifts happen on the edge that enters HIGH (sample) or LOW (advance).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // busy still covers the first IDLE cycle, so a start there is dropped too
                    if (start && !busy) begin
                        tx_shift <= din;
                        bit_cnt  <= '0;
                        state    <= LEAD;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        rx_shift <= {rx_shift[WIDTH-2:0], miso_s2};
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        if (bit_cnt == BW'(WIDTH - 1)) begin
                            state <= TRAIL;
                        end else begin
                            tx_shift <= tx_shift << 1;
                            bit_cnt  <= bit_cnt + BW'(1);
                            state    <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (tick) begin
                        rx_shift <= {rx_shift[WIDTH-2:0], miso_s2};
                        state    <= HIGH;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pin and status registers trail the phase state by one clock so every output is flop-driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck  <= 1'b0;
            ss   <= 1'b1;
            mosi <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            dout <= '0;
        end else begin
            sck  <= (state == HIGH);
            ss   <= !frame_active;
            // tx_shift only moves at start and on LOW entry, so mosi only moves in LEAD or on sck fall
            mosi <= tx_shift[WIDTH-1];
            busy <= (state != IDLE);
            done <= gap_entry;
            if (gap_entry) begin
                dout <= rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed vector bench for spi_master
module tb_spi_master;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       busy, done, sck, ss, mosi, miso;

    logic       start2 = 1'b0;
    logic [7:0] din2 = 8'h00;
    logic [7:0] dout2;
    logic       busy2, done2, sck2, ss2, mosi2;

    always #5 clk = ~clk;

    // Mode-0 slave model or loopback on the CLK_DIV=4 instance
    logic       loop_mode = 1'b1;
    logic [7:0] sl_tx = 8'h00;
    logic [7:0] sl_rx = 8'h00;
    logic [3:0] sl_idx = 4'd0;

    assign miso = loop_mode ? mosi :
                  ((sl_idx < 4'd8) ? sl_tx[3'd7 - sl_idx[2:0]] : 1'b0);

    always @(negedge sck or posedge ss) begin
        if (ss) sl_idx <= 4'd0;
        else    sl_idx <= sl_idx + 4'd1;
    end

    always @(posedge sck) begin
        if (!ss) sl_rx <= {sl_rx[6:0], mosi};
    end

    int hi_run = 0;
    int last_hi_run = 0;
    always @(negedge clk) begin
        if (ss) begin
            hi_run <= hi_run + 1;
        end else begin
            if (hi_run != 0) last_hi_run <= hi_run;
            hi_run <= 0;
        end
    end

    spi_master #(.CLK_DIV(DIV), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .dout(dout),
        .busy(busy), .done(done), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
    );

    spi_master #(.CLK_DIV(500), .WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .din(din2), .dout(dout2),
        .busy(busy2), .done(done2), .sck(sck2), .ss(ss2), .mosi(mosi2), .miso(mosi2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    int         r_rises, r_first_rise, r_done_cycle, r_done_cnt, r_busy_fall, r_ss_low;
    logic       r_ss_glitch, r_dout_early;
    logic [7:0] r_mosi, r_dout;

    // Cycle k = values seen just after the k-th rising edge following the start-sampling edge (k=0)
    task automatic run_frame(input logic [7:0] d, input logic inject, input logic abort);
        logic       prev_sck;
        logic [7:0] dout0;
        r_rises = 0; r_first_rise = -1; r_done_cycle = -1; r_done_cnt = 0;
        r_busy_fall = -1; r_ss_low = -1; r_ss_glitch = 1'b0; r_dout_early = 1'b0;
        r_mosi = 8'h00; r_dout = 8'h00;
        @(negedge clk);
        din = d; start = 1'b1; dout0 = dout;
        @(negedge clk);
        start = 1'b0; din = 8'h00; prev_sck = sck;
        if (!ss) r_ss_low = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = inject && (k == 20);
            if (inject && k == 20) din = 8'hFF;
            if (sck && !prev_sck) begin
                r_rises++;
                if (r_first_rise < 0) r_first_rise = k;
                r_mosi = {r_mosi[6:0], mosi};
            end
            prev_sck = sck;
            if (done) begin
                r_done_cnt++;
                if (r_done_cycle < 0) begin
                    r_done_cycle = k;
                    r_dout = dout;
                end
            end else if (r_done_cnt == 0 && dout != dout0) begin
                r_dout_early = 1'b1;
            end
            if (!ss && r_ss_low < 0) r_ss_low = k;
            if (ss && r_ss_low >= 0 && r_done_cnt == 0) r_ss_glitch = 1'b1;
            if (abort && r_rises == 3) begin
                rst = 1'b1;
                #1;
                check("abort_sck", int'(sck), 0);
                check("abort_ss", int'(ss), 1);
                check("abort_busy", int'(busy), 0);
                check("abort_dout", int'(dout), 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (!busy && k >= 2) begin
                r_busy_fall = k;
                return;
            end
        end
    endtask

    task automatic check_frame(input logic [7:0] exp_dout, input logic [7:0] d);
        check("mosi_bits", int'(r_mosi), int'(d));
        check("sck_rises", r_rises, 8);
        check("first_rise", r_first_rise, DIV + 1);
        check("ss_fall", r_ss_low, 1);
        check("ss_glitch", int'(r_ss_glitch), 0);
        check("done_cycle", r_done_cycle, 17 * DIV + 1);
        check("done_pulses", r_done_cnt, 1);
        check("dout", int'(r_dout), int'(exp_dout));
        check("dout_early", int'(r_dout_early), 0);
        check("busy_fall", r_busy_fall, 18 * DIV + 1);
        check("slave_rx", int'(sl_rx), int'(d));
    endtask

    task automatic run_frame2(input logic [7:0] d);
        int         rise_k = -1;
        int         rise2_k = -1;
        int         fall_k = -1;
        int         done_k = -1;
        logic       ps;
        logic [7:0] dd = 8'h00;
        @(negedge clk);
        din2 = d; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; ps = sck2;
        for (int k = 1; k <= 20000; k++) begin
            @(negedge clk);
            if (sck2 && !ps) begin
                if (rise_k < 0) rise_k = k;
                else if (rise2_k < 0) rise2_k = k;
            end
            if (!sck2 && ps && fall_k < 0) fall_k = k;
            ps = sck2;
            if (done2 && done_k < 0) begin
                done_k = k;
                dd = dout2;
            end
            if (!busy2 && k >= 2) break;
        end
        check("s2_dout", int'(dd), int'(d));
        check("s2_first_rise", rise_k, 501);
        check("s2_high_half", fall_k - rise_k, 500);
        check("s2_period", rise2_k - rise_k, 1000);
        check("s2_done_cycle", done_k, 8501);
    endtask

    typedef struct {
        logic [7:0] din;
        logic       loop;
        logic [7:0] sl_tx;
        logic       inject;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'h00, 1'b0, 8'hA5};
        vecs[1] = '{8'hC3, 1'b0, 8'h3C, 1'b0, 8'h3C};
        vecs[2] = '{8'hFF, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[3] = '{8'h5A, 1'b1, 8'h00, 1'b1, 8'h5A};
        vecs[4] = '{8'h3C, 1'b0, 8'hA5, 1'b0, 8'hA5};

        repeat (3) @(negedge clk);
        check("rst_sck", int'(sck), 0);
        check("rst_ss", int'(ss), 1);
        check("rst_mosi", int'(mosi), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dout", int'(dout), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            loop_mode = vecs[i].loop;
            sl_tx     = vecs[i].sl_tx;
            run_frame(vecs[i].din, vecs[i].inject, 1'b0);
            check_frame(vecs[i].exp_dout, vecs[i].din);
            check("ss_gap", int'(last_hi_run >= DIV), 1);
        end

        // Reset after the third sck rise, then a clean frame
        loop_mode = 1'b1;
        run_frame(8'h96, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("post_abort_dout", int'(dout), 0);
        check("post_abort_busy", int'(busy), 0);
        run_frame(8'h96, 1'b0, 1'b0);
        check_frame(8'h96, 8'h96);

        // Back-to-back loopback frames at the full-size divider
        run_frame2(8'h01);
        run_frame2(8'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
